// File: rtl/ram_access_arbiter_pkg.sv
// Shared types for the packet RAM arbiter:
// FSM state encoding and requester tags.
package ram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  typedef logic tag_t;

  localparam tag_t TAG_A = 1'b0;
  localparam tag_t TAG_B = 1'b1;

endpackage

// File: rtl/ram_rd_return_pipe.sv
// Carries {valid,tag} of issued reads alongside the RAM
// read latency and decodes the per-requester strobes.
module ram_rd_return_pipe
  import ram_access_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk_in,
  input  logic rst,
  input  logic rd_valid,
  input  tag_t rd_tag,
  output logic rvalid_a,
  output logic rvalid_b
);

  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] tag;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      vld <= '0;
      tag <= '0;
    end else begin
      vld[0] <= rd_valid;
      tag[0] <= rd_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign rvalid_a = vld[RD_LAT-1] &&
                    (tag[RD_LAT-1] == TAG_A);
  assign rvalid_b = vld[RD_LAT-1] &&
                    (tag[RD_LAT-1] == TAG_B);

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin, burst-bounded arbiter for a single-port
// packet RAM with registered commands and write counting.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int PKT_LEN   = 32,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              pkt_clr,
  output logic              pkt_full,
  output logic              wr_drop
);

  localparam int CNT_W = $clog2(PKT_LEN + 1);
  localparam int BST_W =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BST_W-1:0] BURST_LAST =
    BST_W'(MAX_BURST - 1);

  state_t            state;
  state_t            state_nxt;
  logic              ptr_b;
  logic [BST_W-1:0]  burst_cnt;
  logic              burst_end;
  logic [CNT_W-1:0]  wr_cnt;
  logic              acc;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              full_eff;
  tag_t              ram_tag;

  assign burst_end = (burst_cnt == BURST_LAST);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_a && req_b)
          state_nxt = ptr_b ? OWN_B : OWN_A;
        else if (req_a)
          state_nxt = OWN_A;
        else if (req_b)
          state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a)
          state_nxt = req_b ? OWN_B : IDLE;
        else if (req_b && burst_end)
          state_nxt = OWN_B;
      end
      OWN_B: begin
        if (!req_b)
          state_nxt = req_a ? OWN_A : IDLE;
        else if (req_a && burst_end)
          state_nxt = OWN_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_a = (state == OWN_A);
    gnt_b = (state == OWN_B);
  end

  // burst_cnt saturates so a late request from the
  // other side takes over after the next access
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ptr_b     <= 1'b0;
      burst_cnt <= '0;
    end else if (state_nxt != state) begin
      burst_cnt <= '0;
      if (state_nxt == OWN_A)      ptr_b <= 1'b1;
      else if (state_nxt == OWN_B) ptr_b <= 1'b0;
    end else if (acc && !burst_end) begin
      burst_cnt <= burst_cnt + BST_W'(1);
    end
  end

  assign acc       = (req_a & gnt_a) | (req_b & gnt_b);
  assign acc_we    = gnt_b ? we_b    : we_a;
  assign acc_addr  = gnt_b ? addr_b  : addr_a;
  assign acc_wdata = gnt_b ? wdata_b : wdata_a;

  assign pkt_full = (wr_cnt == CNT_W'(PKT_LEN));
  // a same-cycle clear frees room for the write
  assign full_eff = pkt_full & ~pkt_clr;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      wr_drop   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_tag   <= TAG_A;
    end else begin
      ram_we  <= acc & acc_we & ~full_eff;
      ram_re  <= acc & ~acc_we;
      wr_drop <= acc & acc_we & full_eff;
      ram_tag <= gnt_b ? TAG_B : TAG_A;
      if (acc) begin
        ram_addr  <= acc_addr;
        ram_wdata <= acc_wdata;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      wr_cnt <= '0;
    else if (pkt_clr)
      wr_cnt <= (acc & acc_we) ? CNT_W'(1) : '0;
    else if (acc & acc_we & ~pkt_full)
      wr_cnt <= wr_cnt + CNT_W'(1);
  end

  ram_rd_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_in   (clk_in),
    .rst      (rst),
    .rd_valid (ram_re),
    .rd_tag   (ram_tag),
    .rvalid_a (rvalid_a),
    .rvalid_b (rvalid_b)
  );

  assign rdata = (rvalid_a | rvalid_b) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: grant table, scoreboarded
// RAM commands and read returns, packet-count corners.
module tb_ram_access_arbiter;

  localparam int PKT = 32;

  typedef struct {
    int         cyc;
    logic       we;
    logic       re;
    logic       drop;
    logic [4:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct {
    int         cyc;
    logic       side_b;
    logic [7:0] data;
  } rd_t;

  typedef struct {
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
  } vec_t;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, we_a = 1'b0;
  logic [4:0] addr_a = '0;
  logic [7:0] wdata_a = '0;
  logic       req_b = 1'b0, we_b = 1'b0;
  logic [4:0] addr_b = '0;
  logic [7:0] wdata_b = '0;
  logic       gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [7:0] rdata;
  logic       ram_we, ram_re;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       pkt_clr = 1'b0;
  logic       pkt_full, wr_drop;
  logic [28:0] outs;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int m_cnt = 0;
  bit sh_rdy = 0;
  bit ram_rdy = 0;
  logic [7:0] ram_mem [32];
  logic [7:0] shadow [32];
  cmd_t cq[$];
  rd_t  rq[$];

  always #5 clk_in = ~clk_in;

  ram_access_arbiter dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .req_a     (req_a),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .gnt_a     (gnt_a),
    .rvalid_a  (rvalid_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .gnt_b     (gnt_b),
    .rvalid_b  (rvalid_b),
    .rdata     (rdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .pkt_clr   (pkt_clr),
    .pkt_full  (pkt_full),
    .wr_drop   (wr_drop)
  );

  assign outs = {gnt_a, rvalid_a, gnt_b, rvalid_b,
                 rdata, ram_we, ram_re, ram_addr,
                 ram_wdata, pkt_full, wr_drop};

  // RAM model, 1-cycle read latency
  always @(posedge clk_in) begin
    if (!ram_rdy) begin
      for (int i = 0; i < 32; i++)
        ram_mem[i] <= 8'hA0 ^ 8'(i);
      ram_rdy <= 1'b1;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // monitor: model + scoreboards, sampled at negedge
  always @(negedge clk_in) begin
    cmd_t c;
    rd_t  r;
    logic aa, ab, w, full_e;
    logic [4:0] ad;
    logic [7:0] dt;
    cyc++;
    if (!sh_rdy) begin
      for (int i = 0; i < 32; i++)
        shadow[i] = 8'hA0 ^ 8'(i);
      sh_rdy = 1;
    end
    if (rst) begin
      cq.delete();
      rq.delete();
      m_cnt = 0;
    end else begin
      if (cq.size() != 0 && cq[0].cyc == cyc) begin
        c = cq.pop_front();
        nvec++;
        if (ram_we !== c.we || ram_re !== c.re ||
            wr_drop !== c.drop ||
            ((c.we || c.re) && ram_addr !== c.addr) ||
            (c.we && ram_wdata !== c.data)) begin
          nmis++;
          $display("FAIL cmd @%0d: got we%b re%b drop%b a%0d d%h want we%b re%b drop%b a%0d d%h",
                   cyc, ram_we, ram_re, wr_drop, ram_addr,
                   ram_wdata, c.we, c.re, c.drop, c.addr,
                   c.data);
        end
      end else if (ram_we || ram_re || wr_drop) begin
        nvec++;
        nmis++;
        $display("FAIL stray_cmd @%0d: we%b re%b drop%b want 000",
                 cyc, ram_we, ram_re, wr_drop);
      end
      while (rq.size() != 0 && rq[0].cyc < cyc) begin
        r = rq.pop_front();
        nvec++;
        nmis++;
        $display("FAIL missing_rvalid @%0d: got none want data %h",
                 r.cyc, r.data);
      end
      if (rvalid_a || rvalid_b) begin
        nvec++;
        if (rq.size() == 0) begin
          nmis++;
          $display("FAIL stray_rvalid @%0d: got a%b b%b want none",
                   cyc, rvalid_a, rvalid_b);
        end else begin
          r = rq.pop_front();
          if (r.cyc != cyc || rvalid_a !== !r.side_b ||
              rvalid_b !== r.side_b || rdata !== r.data) begin
            nmis++;
            $display("FAIL rvalid @%0d: got a%b b%b d%h want @%0d side_b%b d%h",
                     cyc, rvalid_a, rvalid_b, rdata, r.cyc,
                     r.side_b, r.data);
          end
        end
      end
      if (gnt_a || gnt_b) begin
        nvec++;
        if (gnt_a && gnt_b) begin
          nmis++;
          $display("FAIL gnt_overlap @%0d: got 11 want one-hot", cyc);
        end
      end
      nvec++;
      if (pkt_full !== (m_cnt == PKT)) begin
        nmis++;
        $display("FAIL pkt_full @%0d: got %b want %b",
                 cyc, pkt_full, m_cnt == PKT);
      end
      aa = req_a && gnt_a;
      ab = req_b && gnt_b;
      w  = ab ? we_b : we_a;
      ad = ab ? addr_b : addr_a;
      dt = ab ? wdata_b : wdata_a;
      full_e = (m_cnt == PKT) && !pkt_clr;
      if (pkt_clr) m_cnt = 0;
      if (aa || ab) begin
        if (w && full_e) begin
          cq.push_back('{cyc + 1, 1'b0, 1'b0, 1'b1, ad, dt});
        end else if (w) begin
          cq.push_back('{cyc + 1, 1'b1, 1'b0, 1'b0, ad, dt});
          shadow[ad] = dt;
          m_cnt++;
        end else begin
          cq.push_back('{cyc + 1, 1'b0, 1'b1, 1'b0, ad, dt});
          rq.push_back('{cyc + 2, ab, shadow[ad]});
        end
      end
    end
  end

  task automatic do_access(input bit side_b,
                           input logic we,
                           input logic [4:0] a,
                           input logic [7:0] d,
                           input bit clr,
                           output int waits);
    waits = 0;
    if (side_b) begin
      req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
    end
    pkt_clr = clr;
    @(negedge clk_in);
    while (!(side_b ? gnt_b : gnt_a) && waits < 20) begin
      @(negedge clk_in);
      waits++;
    end
    if (!(side_b ? gnt_b : gnt_a)) begin
      nvec++;
      nmis++;
      $display("FAIL grant_timeout: got no grant side_b=%0d want grant",
               side_b);
    end
    @(posedge clk_in);
    #1;
    pkt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   w;
    int   wsum;
    vec_t tbl [20];

    for (int i = 0; i < 20; i++) tbl[i] = '{1, 1, 0, 0};
    for (int i = 1; i <= 4; i++)  tbl[i].gnt_a = 1;
    for (int i = 5; i <= 8; i++)  tbl[i].gnt_b = 1;
    for (int i = 9; i <= 12; i++) tbl[i].gnt_a = 1;
    tbl[13] = '{0, 1, 0, 1};
    tbl[14] = '{0, 0, 0, 1};
    tbl[15] = '{0, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 0};
    tbl[17] = '{1, 0, 1, 0};
    tbl[18] = '{0, 0, 1, 0};
    tbl[19] = '{0, 0, 0, 0};

    // reset
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_outputs", 32'(outs), 32'd0);
    @(posedge clk_in);
    #1 rst = 1'b0;
    @(negedge clk_in);
    check("post_reset_outputs", 32'(outs), 32'd0);
    @(posedge clk_in);
    #1;

    // round-robin with bounded bursts, A first
    for (int i = 0; i < 20; i++) begin
      req_a = tbl[i].req_a;
      req_b = tbl[i].req_b;
      we_a = 1'b0;
      we_b = 1'b0;
      addr_a = 5'(i);
      addr_b = 5'(i + 8);
      @(negedge clk_in);
      check($sformatf("grant_row%0d", i),
            {30'd0, gnt_a, gnt_b},
            {30'd0, tbl[i].gnt_a, tbl[i].gnt_b});
      @(posedge clk_in);
      #1;
    end

    // A alone: 9 back-to-back writes
    wsum = 0;
    for (int i = 0; i < 9; i++) begin
      do_access(0, 1'b1, 5'(i), 8'h56 + 8'(i), 0, w);
      if (i == 0) check("first_grant_latency", w, 1);
      else wsum += w;
    end
    check("b2b_write_waits", wsum, 0);
    req_a = 1'b0;
    @(negedge clk_in);
    check("pkt_full_after_9", 32'(pkt_full), 0);
    @(posedge clk_in);
    #1;

    // A reads addr 1..5
    wsum = 0;
    for (int i = 1; i <= 5; i++) begin
      do_access(0, 1'b0, 5'(i), 8'h00, 0, w);
      if (i == 1) check("read_grant_latency", w, 1);
      else wsum += w;
    end
    check("b2b_read_waits", wsum, 0);
    req_a = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;

    // fill to a full packet
    for (int i = 9; i < 32; i++)
      do_access(0, 1'b1, 5'(i), 8'h3C ^ 8'(i), 0, w);
    req_a = 1'b0;
    @(negedge clk_in);
    check("pkt_full_at_32", 32'(pkt_full), 1);
    @(posedge clk_in);
    #1;
    do_access(0, 1'b1, 5'd0, 8'hEE, 0, w);
    req_a = 1'b0;
    @(negedge clk_in);
    check("drop_no_we", {30'd0, wr_drop, ram_we}, 32'd2);
    @(posedge clk_in);
    #1;
    do_access(0, 1'b1, 5'd1, 8'hC1, 1, w);
    req_a = 1'b0;
    @(negedge clk_in);
    check("clr_with_write", {30'd0, pkt_full, ram_we}, 32'd1);
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 30; i++)
      do_access(0, 1'b1, 5'(i), 8'h90 + 8'(i), 0, w);
    req_a = 1'b0;
    @(negedge clk_in);
    check("count_31_not_full", 32'(pkt_full), 0);
    @(posedge clk_in);
    #1;
    do_access(0, 1'b1, 5'd30, 8'hB0, 0, w);
    req_a = 1'b0;
    @(negedge clk_in);
    check("count_32_full", 32'(pkt_full), 1);
    @(posedge clk_in);
    #1 pkt_clr = 1'b1;
    @(posedge clk_in);
    #1 pkt_clr = 1'b0;
    @(negedge clk_in);
    check("clr_alone", 32'(pkt_full), 0);
    @(posedge clk_in);
    #1;

    // reset with a read in flight
    do_access(0, 1'b0, 5'd3, 8'h00, 0, w);
    rst = 1'b1;
    req_a = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;
    @(negedge clk_in);
    check("idle_after_mid_reset",
          {28'd0, gnt_a, gnt_b, rvalid_a, rvalid_b}, 32'd0);
    @(posedge clk_in);
    #1;
    do_access(1, 1'b0, 5'd7, 8'h00, 0, w);
    check("b_grant_after_reset", w, 1);
    req_b = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
